ex_stage_mdu: RTL and testbench
===============================

Name: ex_stage_mdu

Overview:
- Parametrised execute stage for the rv32im pipeline, XLEN-generic.
- Keeps single-cycle integer ALU ops, the 3-source forwarding muxes and the operand selects for PC/immediate.
- Replaces the combinational M-extension path with a multi-cycle multiplier and an iterative divider behind a stall handshake to the hazard unit.
- Sits between the ID/EX and EX/MEM pipeline registers.

Parameters:
- XLEN, 32, datapath width; must be 32 or 64.
- MUL_STAGES, 2, extra cycles the multiplier occupies after the issue cycle; range 1..4.
- DIV_BITS, 1, quotient bits retired per divider iteration; must be 1 or 2.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- valid_E  in  1  EX holds a real instruction
- flush_E  in  1  kill the instruction in EX, including any in-flight MDU op
- hold_E  in  1  downstream stall; EX must not complete or retire
- reg_read_data_1_E, reg_read_data_2_E  in  XLEN  register operands
- immediate_E, PC_E  in  XLEN  immediate and PC
- selRs1PC_E, selRs2Imm_E  in  1  operand selects
- alu_op_E  in  4  RV32I ALU opcode, existing encoding
- md_en_E  in  1  instruction is an M-extension op
- md_op_E  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- ForwardAE, ForwardBE  in  2  00 reg, 01 mem_read_data_W, 10 ALU_out_M, 11 ALU_out_W
- mem_read_data_W, ALU_out_M, ALU_out_W  in  XLEN  forwarding sources
- ALU_out_E  out  XLEN  result
- rdata2_fd  out  XLEN  forwarded rs2, used as store data
- stall_E  out  1  freeze PC, IF/ID and ID/EX; insert bubble into EX/MEM
- result_valid_E  out  1  ALU_out_E carries a completed result this cycle

Behaviour:
- Reset: FSM goes to IDLE; counters, operand registers and result register clear to 0; stall_E = 0, result_valid_E = 0, ALU_out_E = 0.
- Forwarding and operand selects are combinational:
  - rdata1 = PC_E if selRs1PC_E, else forwarded rs1.
  - rdata2 = immediate_E if selRs2Imm_E, else forwarded rs2.
  - rdata2_fd is always the forwarded rs2, independent of the selects.
- Non-MDU op (valid_E & !md_en_E):
  - Zero latency; ALU_out_E = ALU(rdata1, rdata2).
  - result_valid_E = valid_E & !flush_E; stall_E = 0.
- MDU FSM states: IDLE, MUL, DIV, DONE.
- IDLE, on valid_E & md_en_E & !flush_E (issue cycle T):
  - Latch rdata1/rdata2 and md_op into internal registers. Later forwarding changes must not affect the result.
  - stall_E = 1 combinationally in cycle T.
- Next state after issue:
  - md_op < 4: MUL, with counter = MUL_STAGES-1.
  - Divisor == 0: DONE directly. Quotient = all ones; remainder = dividend.
  - Signed overflow (DIV/REM with dividend = -2^(XLEN-1) and divisor = -1): DONE directly. Quotient = dividend; remainder = 0.
  - Otherwise: DIV, with counter = XLEN/DIV_BITS-1.
- MUL / DIV:
  - stall_E = 1 while in these states.
  - Counter decrements each cycle; when it reaches 0, move to DONE.
  - Divider is restoring, on magnitudes; signs are applied at DONE entry. Quotient sign = sign(a) xor sign(b); remainder takes the sign of the dividend.
  - Multiplier produces the 2*XLEN product. MUL selects the low half; MULH/MULHSU/MULHU select the high half with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- DONE:
  - stall_E = 0, result_valid_E = !hold_E, ALU_out_E = result register.
  - Move to IDLE next cycle unless hold_E; while hold_E = 1, remain in DONE with the result stable.
- Latency (issue cycle through DONE):
  - MUL: DONE at T+MUL_STAGES+1.
  - DIV: DONE at T+XLEN/DIV_BITS+1.
  - Special-case divide: DONE at T+1.
- In DONE the same instruction is still presented on valid_E/md_en_E. The FSM must not re-issue; it issues again only from IDLE.
- flush_E in any state: next state IDLE. result_valid_E = 0 and stall_E = 0 in the flush cycle.
- Asynchronous reset mid-operation aborts immediately; no result is produced.
- hold_E during MUL/DIV is ignored; iteration continues.
- All arithmetic is modulo 2^XLEN; there are no exceptions.

Decomposition:
- Shared package holds:
  - md_op encodings;
  - FSM state enumeration;
  - forwarding-select constants.
- Existing alu_rv32im is reused for RV32I ops only, with Mul_en/Div_en tied low.
- One new sub-module, mdu_iter, contains the FSM, multiplier staging and divider. The top level keeps the forwarding muxes, operand selects and output muxing.

Test Plan:
- ADD with ForwardAE=10, ALU_out_M=5, rs2 imm=7, selRs2Imm_E=1 -> same cycle ALU_out_E=12, result_valid_E=1, stall_E=0; rdata2_fd=reg_read_data_2_E.
- MULH, rs1=0xFFFFFFFF (-1), rs2=2, MUL_STAGES=2 -> stall_E high for 3 cycles; then ALU_out_E=0xFFFFFFFF with result_valid_E=1 for one cycle; changing ForwardAE mid-op has no effect.
- DIV -7/2 and REM -7/2, DIV_BITS=1 -> 33 stall cycles; quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Repeat with DIV_BITS=2 -> 17 stall cycles, same values.
- DIVU 100/0 -> 1 stall cycle, quotient 0xFFFFFFFF; REM 0x80000000/-1 -> remainder 0; DIV 0x80000000/-1 -> quotient 0x80000000.
- DIVU issued, flush_E asserted at stall cycle 10 -> FSM IDLE next cycle, no result_valid_E; a following ADD completes normally.
- MUL reaches DONE with hold_E=1 for 3 cycles -> result stable, no re-issue, result_valid_E=0 until hold_E drops, then a single result_valid_E pulse. Reset asserted mid-DIV -> all outputs 0 immediately.

Source files
------------

// File: rtl/ex_stage_mdu_pkg.sv
// Shared encodings for the execute stage: M-extension ops, MDU states,
// forwarding selects and the RV32I ALU opcodes.
package ex_stage_mdu_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEM_W = 2'b01;
  localparam logic [1:0] FWD_ALU_M = 2'b10;
  localparam logic [1:0] FWD_ALU_W = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

endpackage

// File: rtl/alu_rv32im.sv
// Single-cycle integer ALU; the M-extension enables are kept for interface
// compatibility and force a zero result, since M ops live in mdu_iter.
module alu_rv32im
  import ex_stage_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_op,
  input  logic            Mul_en,
  input  logic            Div_en,
  output logic [XLEN-1:0] y
);
  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] shamt;
  assign shamt = b[SW-1:0];

  always_comb begin
    y = '0;
    case (alu_op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << shamt;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      ALU_LUI:  y = b;
      default:  y = '0;
    endcase
    if (Mul_en || Div_en) y = '0;
  end
endmodule

// File: rtl/ex_stage_mdu_mdu_iter.sv
// Multi-cycle M-extension unit: latched operands, delayed multiplier result
// and a restoring divider retiring DIV_BITS quotient bits per cycle.
module mdu_iter
  import ex_stage_mdu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_BITS   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic            hold,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  md_op_e          md_op,
  output logic            stall,
  output logic            idle,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int DIV_ITERS = XLEN / DIV_BITS;
  localparam int CW = $clog2(DIV_ITERS) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e state_reg, state_next;
  md_op_e op_reg, op_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [XLEN-1:0] a_reg, a_next, b_reg, b_next, rem_reg, rem_next;
  logic [XLEN-1:0] result_reg, result_next;
  logic neg_q_reg, neg_q_next, neg_r_reg, neg_r_next;

  logic signed_div, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  always_comb begin
    signed_div = md_op[2] & ~md_op[0];
    a_neg = signed_div & op_a[XLEN-1];
    b_neg = signed_div & op_b[XLEN-1];
    a_mag = a_neg ? -op_a : op_a;
    b_mag = b_neg ? -op_b : op_b;
  end

  // Explicit extension to 2*XLEN makes one unsigned multiply serve all signedness mixes.
  logic a_sx, b_sx;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN-1:0] mul_res;
  always_comb begin
    a_sx = (op_reg == MD_MULH || op_reg == MD_MULHSU) && a_reg[XLEN-1];
    b_sx = (op_reg == MD_MULH) && b_reg[XLEN-1];
    mul_a = {{XLEN{a_sx}}, a_reg};
    mul_b = {{XLEN{b_sx}}, b_reg};
    prod = mul_a * mul_b;
    mul_res = (op_reg == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // a_reg doubles as the dividend/quotient shift register during DIV.
  logic [XLEN:0] r_step;
  logic [XLEN-1:0] q_step, q_fin, r_fin, div_res;
  always_comb begin
    r_step = {1'b0, rem_reg};
    q_step = a_reg;
    for (int i = 0; i < DIV_BITS; i++) begin
      r_step = {r_step[XLEN-1:0], q_step[XLEN-1]};
      q_step = {q_step[XLEN-2:0], 1'b0};
      if (r_step >= {1'b0, b_reg}) begin
        r_step = r_step - {1'b0, b_reg};
        q_step[0] = 1'b1;
      end
    end
    q_fin = neg_q_reg ? -q_step : q_step;
    r_fin = neg_r_reg ? -r_step[XLEN-1:0] : r_step[XLEN-1:0];
    div_res = op_reg[1] ? r_fin : q_fin;
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    cnt_next    = cnt_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    rem_next    = rem_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    result_next = result_reg;
    case (state_reg)
      S_IDLE: begin
        if (start && !flush) begin
          op_next = md_op;
          if (!md_op[2]) begin
            a_next     = op_a;
            b_next     = op_b;
            cnt_next   = CW'(MUL_STAGES - 1);
            state_next = S_MUL;
          end else if (op_b == '0) begin
            result_next = md_op[1] ? op_a : '1;
            state_next  = S_DONE;
          end else if (signed_div && op_a == MIN_NEG && op_b == '1) begin
            result_next = md_op[1] ? '0 : op_a;
            state_next  = S_DONE;
          end else begin
            a_next     = a_mag;
            b_next     = b_mag;
            rem_next   = '0;
            neg_q_next = a_neg ^ b_neg;
            neg_r_next = a_neg;
            cnt_next   = CW'(DIV_ITERS - 1);
            state_next = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (cnt_reg == '0) begin
          result_next = mul_res;
          state_next  = S_DONE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      S_DIV: begin
        a_next   = q_step;
        rem_next = r_step[XLEN-1:0];
        if (cnt_reg == '0) begin
          result_next = div_res;
          state_next  = S_DONE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      S_DONE: begin
        if (!hold) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      op_reg     <= MD_MUL;
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      rem_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      cnt_reg    <= cnt_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      rem_reg    <= rem_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      result_reg <= result_next;
    end
  end

  assign stall  = !flush && ((state_reg == S_IDLE && start) ||
                             state_reg == S_MUL || state_reg == S_DIV);
  assign idle   = (state_reg == S_IDLE);
  assign done   = (state_reg == S_DONE);
  assign result = result_reg;
endmodule

// File: rtl/ex_stage_mdu.sv
// Execute stage: forwarding muxes, operand selects, single-cycle ALU and
// a stalling multi-cycle MDU, with output muxing between the two.
module ex_stage_mdu
  import ex_stage_mdu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_BITS   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_E,
  input  logic            flush_E,
  input  logic            hold_E,
  input  logic [XLEN-1:0] reg_read_data_1_E,
  input  logic [XLEN-1:0] reg_read_data_2_E,
  input  logic [XLEN-1:0] immediate_E,
  input  logic [XLEN-1:0] PC_E,
  input  logic            selRs1PC_E,
  input  logic            selRs2Imm_E,
  input  logic [3:0]      alu_op_E,
  input  logic            md_en_E,
  input  logic [2:0]      md_op_E,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] mem_read_data_W,
  input  logic [XLEN-1:0] ALU_out_M,
  input  logic [XLEN-1:0] ALU_out_W,
  output logic [XLEN-1:0] ALU_out_E,
  output logic [XLEN-1:0] rdata2_fd,
  output logic            stall_E,
  output logic            result_valid_E
);
  logic [XLEN-1:0] fwd_a, fwd_b, rdata1, rdata2, alu_res, md_res;
  logic md_stall, md_idle, md_done;

  always_comb begin
    case (ForwardAE)
      FWD_MEM_W: fwd_a = mem_read_data_W;
      FWD_ALU_M: fwd_a = ALU_out_M;
      FWD_ALU_W: fwd_a = ALU_out_W;
      default:   fwd_a = reg_read_data_1_E;
    endcase
    case (ForwardBE)
      FWD_MEM_W: fwd_b = mem_read_data_W;
      FWD_ALU_M: fwd_b = ALU_out_M;
      FWD_ALU_W: fwd_b = ALU_out_W;
      default:   fwd_b = reg_read_data_2_E;
    endcase
    rdata1 = selRs1PC_E ? PC_E : fwd_a;
    rdata2 = selRs2Imm_E ? immediate_E : fwd_b;
  end

  assign rdata2_fd = fwd_b;

  alu_rv32im #(.XLEN(XLEN)) u_alu (
    .a      (rdata1),
    .b      (rdata2),
    .alu_op (alu_op_E),
    .Mul_en (1'b0),
    .Div_en (1'b0),
    .y      (alu_res)
  );

  mdu_iter #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES), .DIV_BITS(DIV_BITS)) u_mdu (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (valid_E && md_en_E),
    .flush  (flush_E),
    .hold   (hold_E),
    .op_a   (rdata1),
    .op_b   (rdata2),
    .md_op  (md_op_e'(md_op_E)),
    .stall  (md_stall),
    .idle   (md_idle),
    .done   (md_done),
    .result (md_res)
  );

  // Outputs are gated by rst_n so an asserted reset silences them without a clock.
  always_comb begin
    stall_E        = rst_n && md_stall;
    result_valid_E = rst_n && !flush_E &&
                     ((md_done && !hold_E) || (md_idle && valid_E && !md_en_E));
    ALU_out_E      = !rst_n ? '0 : (md_done ? md_res : alu_res);
  end
endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed bench for ex_stage_mdu: one instance with DIV_BITS=1 and a
// second with DIV_BITS=2 sharing all inputs except valid.
module tb_ex_stage_mdu;
  import ex_stage_mdu_pkg::*;

  logic clk = 1'b0;
  logic rst_n, valid_E, valid2_E, flush_E, hold_E;
  logic [31:0] reg_read_data_1_E, reg_read_data_2_E, immediate_E, PC_E;
  logic selRs1PC_E, selRs2Imm_E, md_en_E;
  logic [3:0] alu_op_E;
  logic [2:0] md_op_E;
  logic [1:0] ForwardAE, ForwardBE;
  logic [31:0] mem_read_data_W, ALU_out_M, ALU_out_W;
  logic [31:0] ALU_out_E, rdata2_fd, ALU_out2_E, rdata2_fd2;
  logic stall_E, result_valid_E, stall2_E, result_valid2_E;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_stage_mdu #(.XLEN(32), .MUL_STAGES(2), .DIV_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .valid_E(valid_E), .flush_E(flush_E), .hold_E(hold_E),
    .reg_read_data_1_E(reg_read_data_1_E), .reg_read_data_2_E(reg_read_data_2_E),
    .immediate_E(immediate_E), .PC_E(PC_E), .selRs1PC_E(selRs1PC_E),
    .selRs2Imm_E(selRs2Imm_E), .alu_op_E(alu_op_E), .md_en_E(md_en_E), .md_op_E(md_op_E),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_read_data_W(mem_read_data_W),
    .ALU_out_M(ALU_out_M), .ALU_out_W(ALU_out_W), .ALU_out_E(ALU_out_E),
    .rdata2_fd(rdata2_fd), .stall_E(stall_E), .result_valid_E(result_valid_E)
  );

  ex_stage_mdu #(.XLEN(32), .MUL_STAGES(2), .DIV_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .valid_E(valid2_E), .flush_E(flush_E), .hold_E(hold_E),
    .reg_read_data_1_E(reg_read_data_1_E), .reg_read_data_2_E(reg_read_data_2_E),
    .immediate_E(immediate_E), .PC_E(PC_E), .selRs1PC_E(selRs1PC_E),
    .selRs2Imm_E(selRs2Imm_E), .alu_op_E(alu_op_E), .md_en_E(md_en_E), .md_op_E(md_op_E),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_read_data_W(mem_read_data_W),
    .ALU_out_M(ALU_out_M), .ALU_out_W(ALU_out_W), .ALU_out_E(ALU_out2_E),
    .rdata2_fd(rdata2_fd2), .stall_E(stall2_E), .result_valid_E(result_valid2_E)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue_md(input bit which, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    valid_E = !which;
    valid2_E = which;
    md_en_E = 1'b1;
    md_op_E = op;
    reg_read_data_1_E = a;
    reg_read_data_2_E = b;
    ForwardAE = FWD_REG;
    ForwardBE = FWD_REG;
    selRs1PC_E = 1'b0;
    selRs2Imm_E = 1'b0;
  endtask

  // Counts stall cycles from the issue cycle, disturbing the forwarding
  // selects after issue, then checks the single-cycle result pulse.
  task automatic run_md(input bit which, input string tag, input int exp_stalls,
                        input logic [31:0] exp_res);
    int stalls = 0;
    @(negedge clk);
    while ((which ? stall2_E : stall_E) === 1'b1 && stalls < 100) begin
      stalls++;
      @(posedge clk); #1;
      ForwardAE = FWD_MEM_W;
      ForwardBE = FWD_ALU_M;
      @(negedge clk);
    end
    chk({tag, " stalls"}, 64'(stalls), 64'(exp_stalls));
    chk({tag, " result"}, which ? ALU_out2_E : ALU_out_E, exp_res);
    chk({tag, " valid"}, which ? result_valid2_E : result_valid_E, 1);
    @(posedge clk); #1;
    valid_E = 1'b0;
    valid2_E = 1'b0;
    md_en_E = 1'b0;
    ForwardAE = FWD_REG;
    ForwardBE = FWD_REG;
    @(negedge clk);
    chk({tag, " pulse"}, which ? result_valid2_E : result_valid_E, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int stalls;
    int pulses;
    rst_n = 1'b0; valid_E = 1'b0; valid2_E = 1'b0; flush_E = 1'b0; hold_E = 1'b0;
    md_en_E = 1'b0; md_op_E = 3'd0; alu_op_E = ALU_ADD;
    reg_read_data_1_E = '0; reg_read_data_2_E = '0; immediate_E = '0; PC_E = '0;
    selRs1PC_E = 1'b0; selRs2Imm_E = 1'b0; ForwardAE = FWD_REG; ForwardBE = FWD_REG;
    mem_read_data_W = 32'h5A5A5A5A; ALU_out_M = 32'hDEAD0000; ALU_out_W = 32'h0BAD0000;

    // Reset state, with an M op presented to prove outputs stay quiet.
    @(posedge clk); #1;
    valid_E = 1'b1; md_en_E = 1'b1;
    @(negedge clk);
    chk("reset stall", stall_E, 0);
    chk("reset valid", result_valid_E, 0);
    chk("reset alu_out", ALU_out_E, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; valid_E = 1'b0; md_en_E = 1'b0;
    @(posedge clk); #1;

    // ADD: rs1 forwarded from MEM, rs2 from immediate.
    valid_E = 1'b1; alu_op_E = ALU_ADD; ForwardAE = FWD_ALU_M; ALU_out_M = 32'd5;
    selRs2Imm_E = 1'b1; immediate_E = 32'd7; reg_read_data_2_E = 32'h1234;
    @(negedge clk);
    chk("add result", ALU_out_E, 32'd12);
    chk("add valid", result_valid_E, 1);
    chk("add stall", stall_E, 0);
    chk("add rdata2_fd", rdata2_fd, 32'h1234);
    @(posedge clk); #1;

    // SUB: rs1 = PC, rs2 forwarded from WB ALU result.
    ForwardAE = FWD_REG; selRs1PC_E = 1'b1; PC_E = 32'h100; selRs2Imm_E = 1'b0;
    ForwardBE = FWD_ALU_W; ALU_out_W = 32'h10; alu_op_E = ALU_SUB;
    @(negedge clk);
    chk("sub result", ALU_out_E, 32'hF0);
    chk("sub rdata2_fd", rdata2_fd, 32'h10);
    chk("sub valid", result_valid_E, 1);
    @(posedge clk); #1;

    // SRA from mem_read_data_W, flushed: no result_valid_E.
    selRs1PC_E = 1'b0; ForwardAE = FWD_MEM_W; mem_read_data_W = 32'h80000000;
    ForwardBE = FWD_REG; reg_read_data_2_E = 32'd4; alu_op_E = ALU_SRA; flush_E = 1'b1;
    @(negedge clk);
    chk("sra result", ALU_out_E, 32'hF8000000);
    chk("sra flushed valid", result_valid_E, 0);
    @(posedge clk); #1;
    flush_E = 1'b0; valid_E = 1'b0; alu_op_E = ALU_ADD;
    mem_read_data_W = 32'h5A5A5A5A; ALU_out_M = 32'hDEAD0000; ALU_out_W = 32'h0BAD0000;
    @(posedge clk); #1;

    // Multiplies (MUL_STAGES=2: 3 stall cycles).
    issue_md(0, MD_MULH, 32'hFFFFFFFF, 32'd2);
    run_md(0, "mulh -1*2", 3, 32'hFFFFFFFF);
    issue_md(0, MD_MULHU, 32'hFFFFFFFF, 32'd2);
    run_md(0, "mulhu", 3, 32'h1);
    issue_md(0, MD_MULHSU, 32'd2, 32'hFFFFFFFF);
    run_md(0, "mulhsu", 3, 32'h1);
    issue_md(0, MD_MUL, 32'h12345678, 32'h10);
    run_md(0, "mul", 3, 32'h23456780);

    // Divides, DIV_BITS=1: 33 stall cycles.
    issue_md(0, MD_DIV, 32'hFFFFFFF9, 32'd2);
    run_md(0, "div -7/2", 33, 32'hFFFFFFFD);
    issue_md(0, MD_REM, 32'hFFFFFFF9, 32'd2);
    run_md(0, "rem -7/2", 33, 32'hFFFFFFFF);
    issue_md(0, MD_DIV, 32'd7, 32'hFFFFFFFE);
    run_md(0, "div 7/-2", 33, 32'hFFFFFFFD);
    issue_md(0, MD_REM, 32'd7, 32'hFFFFFFFE);
    run_md(0, "rem 7/-2", 33, 32'h1);
    issue_md(0, MD_DIVU, 32'd100, 32'd7);
    run_md(0, "divu 100/7", 33, 32'd14);
    issue_md(0, MD_REMU, 32'd100, 32'd7);
    run_md(0, "remu 100/7", 33, 32'd2);

    // Special-case divides: one stall cycle.
    issue_md(0, MD_DIVU, 32'd100, 32'd0);
    run_md(0, "divu by 0", 1, 32'hFFFFFFFF);
    issue_md(0, MD_REMU, 32'd100, 32'd0);
    run_md(0, "remu by 0", 1, 32'd100);
    issue_md(0, MD_REM, 32'h80000000, 32'hFFFFFFFF);
    run_md(0, "rem ovf", 1, 32'h0);
    issue_md(0, MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    run_md(0, "div ovf", 1, 32'h80000000);

    // DIV_BITS=2 instance: 17 stall cycles.
    issue_md(1, MD_DIV, 32'hFFFFFFF9, 32'd2);
    run_md(1, "div2 -7/2", 17, 32'hFFFFFFFD);
    issue_md(1, MD_REM, 32'hFFFFFFF9, 32'd2);
    run_md(1, "rem2 -7/2", 17, 32'hFFFFFFFF);

    // Flush at stall cycle 10 of a DIVU.
    issue_md(0, MD_DIVU, 32'd1000, 32'd3);
    stalls = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (stall_E) stalls++;
      @(posedge clk); #1;
    end
    chk("flush pre stalls", 64'(stalls), 64'(9));
    flush_E = 1'b1;
    @(negedge clk);
    chk("flush stall", stall_E, 0);
    chk("flush valid", result_valid_E, 0);
    @(posedge clk); #1;
    flush_E = 1'b0; valid_E = 1'b0; md_en_E = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid_E || stall_E) pulses++;
      @(posedge clk); #1;
    end
    chk("flush no result", 64'(pulses), 64'(0));
    valid_E = 1'b1; alu_op_E = ALU_ADD; reg_read_data_1_E = 32'd3; reg_read_data_2_E = 32'd4;
    @(negedge clk);
    chk("post-flush add", ALU_out_E, 32'd7);
    chk("post-flush valid", result_valid_E, 1);
    chk("post-flush stall", stall_E, 0);
    @(posedge clk); #1;
    valid_E = 1'b0;
    @(posedge clk); #1;

    // MUL completing into a 3-cycle hold.
    issue_md(0, MD_MUL, 32'd6, 32'd7);
    hold_E = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (stall_E === 1'b1 && stalls < 100) begin
      stalls++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("hold stalls", 64'(stalls), 64'(3));
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        @(negedge clk);
      end
      chk("hold result", ALU_out_E, 32'd42);
      chk("hold valid", result_valid_E, 0);
      chk("hold no reissue", stall_E, 0);
    end
    @(posedge clk); #1;
    hold_E = 1'b0;
    @(negedge clk);
    chk("release result", ALU_out_E, 32'd42);
    chk("release valid", result_valid_E, 1);
    @(posedge clk); #1;
    valid_E = 1'b0; md_en_E = 1'b0;
    @(negedge clk);
    chk("release pulse", result_valid_E, 0);
    chk("release stall", stall_E, 0);
    @(posedge clk); #1;

    // Reset mid-DIV: outputs drop without a clock edge, no result later.
    issue_md(0, MD_DIV, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst stall", stall_E, 0);
    chk("midrst valid", result_valid_E, 0);
    chk("midrst alu_out", ALU_out_E, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; valid_E = 1'b0; md_en_E = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid_E || stall_E) pulses++;
      @(posedge clk); #1;
    end
    chk("midrst no result", 64'(pulses), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
